// File: rtl/timer_sched.sv
// Shared tick-prescaled countdown timer with a round-robin arbiter over NREQ requesters.
// The owner holds grant until its delay expires (one-cycle done) or it drops req (abort).
module timer_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DW          = 16,
  parameter int unsigned TICK_CYCLES = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] delay,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy
);

  localparam int unsigned OW = $clog2(NREQ);
  // A prescaler of one cycle per tick still needs a 1-bit register that simply stays at zero.
  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PreMax = PW'(TICK_CYCLES - 1);
  localparam logic [OW-1:0] LastIdx = OW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t          r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;
  logic [DW-1:0]   r_cnt;
  logic [PW-1:0]   r_pre;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_busy;

  logic            w_found;
  logic [OW-1:0]   w_winner;
  logic [DW-1:0]   w_delay;
  logic [OW-1:0]   w_next_ptr;
  int unsigned     w_idx;

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan from the farthest position back toward ptr so the closest requester is written last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (req[OW'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = OW'(w_idx);
      end
    end
  end

  assign w_delay    = delay[int'(w_winner)*DW +: DW];
  assign w_next_ptr = (r_owner == LastIdx) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_owner <= w_winner;
            r_cnt   <= w_delay;
            r_pre   <= PreMax;
            r_state <= StRun;
            r_grant <= onehot(w_winner);
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          // Abort wins over expiry; cnt stops at zero so the maximum delay cannot wrap.
          if (!req[r_owner]) begin
            r_state <= StIdle;
            r_ptr   <= w_next_ptr;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= StDone;
            r_done  <= onehot(r_owner);
          end else if (r_pre == '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_pre <= PreMax;
          end else begin
            r_pre <= r_pre - 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_ptr   <= w_next_ptr;
          r_grant <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: two instances (4 and 1 clk per tick) checked every cycle against a
// deadline-based transaction model, plus directed latency, ordering, abort and reset scenarios.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req4 = 4'b1111;
  logic [3:0]  req1 = 4'b1111;
  logic [63:0] dly4 = '0;
  logic [63:0] dly1 = '0;
  logic [3:0]  grant4, done4, grant1, done1;
  logic        busy4, busy1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  timer_sched #(.NREQ(4), .DW(16), .TICK_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .delay(dly4),
    .grant(grant4), .done(done4), .busy(busy4)
  );

  timer_sched #(.NREQ(4), .DW(16), .TICK_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .delay(dly1),
    .grant(grant1), .done(done1), .busy(busy1)
  );

  // Model: mode 0 idle, 1 owned and counting toward an absolute deadline cycle, 2 done cycle.
  int     m_mode[2]     = '{0, 0};
  int     m_ptr[2]      = '{0, 0};
  int     m_owner[2]    = '{0, 0};
  longint m_deadline[2] = '{0, 0};
  int     tc[2]         = '{4, 1};
  longint cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input int i, input logic [3:0] r, input logic [63:0] d);
    if (rst) begin
      m_mode[i]  = 0;
      m_ptr[i]   = 0;
      m_owner[i] = 0;
    end else begin
      case (m_mode[i])
        0: begin
          for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr[i] + k) % 4;
            if (r[j]) begin
              m_owner[i]    = j;
              m_deadline[i] = cyc + longint'(d[j*16 +: 16]) * tc[i] + 2;
              m_mode[i]     = 1;
              break;
            end
          end
        end
        1: begin
          if (!r[m_owner[i]]) begin
            m_mode[i] = 0;
            m_ptr[i]  = (m_owner[i] + 1) % 4;
          end else if (cyc + 1 == m_deadline[i]) begin
            m_mode[i] = 2;
          end
        end
        default: begin
          m_mode[i] = 0;
          m_ptr[i]  = (m_owner[i] + 1) % 4;
        end
      endcase
    end
  endtask

  function automatic logic [3:0] exp_grant(input int i);
    return (m_mode[i] != 0) ? 4'(1 << m_owner[i]) : 4'b0;
  endfunction

  function automatic logic [3:0] exp_done(input int i);
    return (m_mode[i] == 2) ? 4'(1 << m_owner[i]) : 4'b0;
  endfunction

  // One clock: advance the model at the edge, compare both instances on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(0, req4, dly4);
    model_step(1, req1, dly1);
    cyc++;
    @(negedge clk);
    check_eq("grant_tc4", grant4, exp_grant(0));
    check_eq("done_tc4", done4, exp_done(0));
    check_eq("busy_tc4", busy4, m_mode[0] != 0);
    check_eq("grant_tc1", grant1, exp_grant(1));
    check_eq("done_tc1", done1, exp_done(1));
    check_eq("busy_tc1", busy1, m_mode[1] != 0);
    check_eq("onehot_tc4", $onehot0(grant4), 1);
    check_eq("onehot_tc1", $onehot0(grant1), 1);
  endtask

  initial begin
    int n;
    bit found;
    int order[$];
    logic [3:0] prev;

    // Reset held with every request asserted.
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("rst_grant", {grant4, grant1}, 8'h00);
      check_eq("rst_done", {done4, done1}, 8'h00);
      check_eq("rst_busy", {busy4, busy1}, 2'b00);
    end
    rst  = 1'b0;
    req4 = '0;
    req1 = '0;
    tick();
    check_eq("post_rst_busy", {busy4, busy1}, 2'b00);

    // 4 clk per tick, requester 1, delay 3: done exactly at T+14.
    dly4[16 +: 16] = 16'd3;
    req4 = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_eq("t2_grant", grant4, (k <= 14) ? 4'b0010 : 4'b0000);
      check_eq("t2_done", done4, (k == 14) ? 4'b0010 : 4'b0000);
      if (k == 14) req4 = '0;
    end
    check_eq("t2_busy_after", busy4, 1'b0);

    // 1 clk per tick, requester 3, delay 0 then maximum delay.
    dly1[48 +: 16] = 16'd0;
    req1 = 4'b1000;
    tick();
    check_eq("t3_grant", grant1, 4'b1000);
    tick();
    check_eq("t3_done_d0", done1, 4'b1000);
    req1 = '0;
    tick();
    dly1[48 +: 16] = 16'hFFFF;
    req1 = 4'b1000;
    n = 0;
    found = 0;
    while (!found && n < 70000) begin
      tick();
      n++;
      if (done1[3]) found = 1;
    end
    check_eq("t3_max_latency", n, 65537);
    req1 = '0;
    tick();

    // All requesting with delay 1: round-robin order 0,1,2,3,0.
    dly1 = {16'd1, 16'd1, 16'd1, 16'd1};
    req1 = 4'b1111;
    prev = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (grant1 != 0 && grant1 != prev) begin
        for (int b = 0; b < 4; b++) if (grant1[b]) order.push_back(b);
      end
      prev = grant1;
    end
    req1 = '0;
    tick();
    check_eq("t4_count", order.size() >= 5, 1);
    for (int k = 0; k < 5 && k < order.size(); k++) check_eq("t4_order", order[k], k % 4);

    // Abort: requester 2 (delay 10) drops out 3 cycles into its run, requester 3 takes over.
    dly4[32 +: 16] = 16'd10;
    dly4[48 +: 16] = 16'd2;
    req4 = 4'b1100;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("t5_grant_run", grant4, 4'b0100);
    end
    req4 = 4'b1000;
    tick();
    check_eq("t5_abort_busy", busy4, 1'b0);
    check_eq("t5_abort_grant", grant4, 4'b0000);
    tick();
    check_eq("t5_next_grant", grant4, 4'b1000);
    req4 = '0;
    tick();
    check_eq("t5_no_done", done4, 4'b0000);

    // Move ptr to 2, then reset while requester 1 owns the timer.
    dly4[16 +: 16] = 16'd0;
    req4 = 4'b0010;
    tick();
    tick();
    req4 = '0;
    tick();
    dly4[16 +: 16] = 16'd20;
    req4 = 4'b0010;
    for (int k = 0; k < 3; k++) tick();
    check_eq("t6_owner1", grant4, 4'b0010);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_idle", {busy4, grant4, done4}, 9'h000);
    rst  = 1'b0;
    req4 = 4'b1010;
    tick();
    check_eq("t6_ptr_reset", grant4, 4'b0010);
    req4 = '0;
    tick();

    // Random traffic on both instances, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 15) == 0) req4[b] = ~req4[b];
        if ($urandom_range(0, 15) == 0) req1[b] = ~req1[b];
        if ($urandom_range(0, 7) == 0)
          dly4[b*16 +: 16] = 16'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 20 : 4));
        if ($urandom_range(0, 7) == 0)
          dly1[b*16 +: 16] = 16'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 40 : 6));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
